pipe_if_queue: RTL and testbench

PIPE_IF_QUEUE -- requirements
Module: pipe_if_queue

---
 rtl/pipe_if_queue.sv | 185 ++++++++++++++++++
 tb/tb_pipe_if_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_queue.sv
// Instruction-fetch front end: issues in-order fetch requests with a bounded number
// outstanding, cancels stale responses after redirects and queues instructions for ID.
module pipe_if_queue #(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          IBUF_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ex_WB,
    input  logic        flush_WB,
    input  logic [31:0] ex_entry,
    output logic        to_valid,
    output logic [31:0] to_pc,
    output logic [31:0] to_inst,
    output logic        to_adef,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int IW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
    localparam int NW = $clog2(IBUF_DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_ADEF  = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } ibuf_entry_t;

    function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [IW-1:0] ibuf_next(input logic [IW-1:0] p);
        return (p == IW'(IBUF_DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] cancel_q, cancel_d;
    logic          adef_stop_q, adef_stop_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
    logic [IW-1:0] ibuf_rd_q, ibuf_rd_d, ibuf_wr_q, ibuf_wr_d;
    logic [NW-1:0] ibuf_cnt_q, ibuf_cnt_d;

    logic [31:0]   pend_pc_q [MAX_OUTSTANDING];
    ibuf_entry_t   ibuf_q    [IBUF_DEPTH];

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          credit_ok;
    logic [1:0]    fetch_state;
    logic          issue, resp, resp_keep, adef_push, ibuf_push, ibuf_pop;
    ibuf_entry_t   ibuf_wdata;

    assign redirect    = ex_WB | flush_WB | br_taken;
    assign redirect_pc = (ex_WB | flush_WB) ? ex_entry : br_target;

    // Data space for every request is reserved at issue, so a response always has room.
    assign credit_ok = (32'(inflight_q) < 32'(MAX_OUTSTANDING)) &&
                       ((32'(inflight_q) + 32'(ibuf_cnt_q)) < 32'(IBUF_DEPTH));

    assign fetch_state = adef_stop_q ? ST_ADEF : (credit_ok ? ST_FETCH : ST_HOLD);

    assign inst_sram_req   = ~reset & ~redirect & (fetch_state == ST_FETCH) &
                             (fetch_pc_q[1:0] == 2'b00);
    assign inst_sram_addr  = fetch_pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    assign issue     = inst_sram_req & inst_sram_addr_ok;
    assign resp      = inst_sram_data_ok & (inflight_q != '0);
    assign resp_keep = resp & (cancel_q == '0) & ~redirect;
    assign adef_push = ~redirect & (fetch_pc_q[1:0] != 2'b00) & (inflight_q == '0) &
                       (cancel_q == '0) & (ibuf_cnt_q != NW'(IBUF_DEPTH)) & ~adef_stop_q;
    assign ibuf_push = resp_keep | adef_push;

    assign to_valid = (ibuf_cnt_q != '0) & ~redirect;
    assign to_pc    = ibuf_q[ibuf_rd_q].pc;
    assign to_inst  = ibuf_q[ibuf_rd_q].inst;
    assign to_adef  = ibuf_q[ibuf_rd_q].adef;
    assign ibuf_pop = to_valid & id_allowin;

    always_comb begin
        ibuf_wdata.pc   = pend_pc_q[pend_rd_q];
        ibuf_wdata.inst = inst_sram_rdata;
        ibuf_wdata.adef = 1'b0;
        if (!resp_keep) begin
            ibuf_wdata.pc   = fetch_pc_q;
            ibuf_wdata.inst = 32'h0;
            ibuf_wdata.adef = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block infers a latch.
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = inflight_q;
        cancel_d    = cancel_q;
        adef_stop_d = adef_stop_q;
        pend_rd_d   = pend_rd_q;
        pend_wr_d   = pend_wr_q;
        ibuf_rd_d   = ibuf_rd_q;
        ibuf_wr_d   = ibuf_wr_q;
        ibuf_cnt_d  = ibuf_cnt_q;

        if (redirect)   fetch_pc_d = redirect_pc;
        else if (issue) fetch_pc_d = fetch_pc_q + 32'd4;

        case ({issue, resp})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase

        if (issue) pend_wr_d = pend_next(pend_wr_q);
        if (resp)  pend_rd_d = pend_next(pend_rd_q);

        // Everything still pending is stale after a redirect, including a response landing now.
        if (redirect)                     cancel_d = inflight_q - CW'(resp);
        else if (resp && cancel_q != '0)  cancel_d = cancel_q - CNT_ONE;

        if (redirect)       adef_stop_d = 1'b0;
        else if (adef_push) adef_stop_d = 1'b1;

        if (redirect) begin
            ibuf_rd_d  = '0;
            ibuf_wr_d  = '0;
            ibuf_cnt_d = '0;
        end else begin
            if (ibuf_push) ibuf_wr_d = ibuf_next(ibuf_wr_q);
            if (ibuf_pop)  ibuf_rd_d = ibuf_next(ibuf_rd_q);
            ibuf_cnt_d = ibuf_cnt_q + NW'(ibuf_push) - NW'(ibuf_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= '0;
            cancel_q    <= '0;
            adef_stop_q <= 1'b0;
            pend_rd_q   <= '0;
            pend_wr_q   <= '0;
            ibuf_rd_q   <= '0;
            ibuf_wr_q   <= '0;
            ibuf_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            cancel_q    <= cancel_d;
            adef_stop_q <= adef_stop_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            ibuf_rd_q   <= ibuf_rd_d;
            ibuf_wr_q   <= ibuf_wr_d;
            ibuf_cnt_q  <= ibuf_cnt_d;
        end
    end

    // NOTE: storage arrays carry no reset; reset pointers and counts make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (issue)     pend_pc_q[pend_wr_q] <= fetch_pc_q;
        if (ibuf_push) ibuf_q[ibuf_wr_q]    <= ibuf_wdata;
    end

endmodule

// File: tb/tb_pipe_if_queue.sv
// Directed bench for pipe_if_queue: an in-order memory model with one-cycle data latency
// feeds the fetch unit, and every instruction handed to ID is logged and compared.
module tb_pipe_if_queue;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ex_WB;
    logic        flush_WB;
    logic [31:0] ex_entry;
    logic        to_valid;
    logic [31:0] to_pc;
    logic [31:0] to_inst;
    logic        to_adef;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    pipe_if_queue #(
        .RESET_PC        (RESET_PC),
        .MAX_OUTSTANDING (2),
        .IBUF_DEPTH      (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .id_allowin        (id_allowin),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .ex_WB             (ex_WB),
        .flush_WB          (flush_WB),
        .ex_entry          (ex_entry),
        .to_valid          (to_valid),
        .to_pc             (to_pc),
        .to_inst           (to_inst),
        .to_adef           (to_adef),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h0bad_f00d;
    endfunction

    // Memory model and observation log
    bit          mem_ack, dok_en, stray_dok;
    logic [31:0] mem_q [$];
    logic [31:0] seen_pc [$];
    logic [31:0] seen_inst [$];
    logic        seen_adef [$];
    int          seen_cyc [$];
    int          cyc = 0;
    int          acc_cnt = 0;
    logic        s_req, s_valid, s_adef;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic tick();
        @(negedge clk);
        inst_sram_addr_ok = mem_ack;
        if (dok_en && mem_q.size() > 0) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = mem_word(mem_q[0]);
        end else if (stray_dok) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata   = 32'hdeadbeef;
        end else begin
            inst_sram_data_ok = 1'b0;
            inst_sram_rdata   = 32'h0;
        end
        #1;
        s_req   = inst_sram_req;
        s_addr  = inst_sram_addr;
        s_valid = to_valid;
        s_pc    = to_pc;
        s_inst  = to_inst;
        s_adef  = to_adef;
        if (to_valid && id_allowin) begin
            seen_pc.push_back(to_pc);
            seen_inst.push_back(to_inst);
            seen_adef.push_back(to_adef);
            seen_cyc.push_back(cyc);
        end
        if (inst_sram_data_ok && mem_q.size() > 0 && !reset) void'(mem_q.pop_front());
        if (inst_sram_req && inst_sram_addr_ok) begin
            mem_q.push_back(inst_sram_addr);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic int seen_cycle(input int idx);
        return (idx < seen_cyc.size()) ? seen_cyc[idx] : -1;
    endfunction

    task automatic expect_seen(input string tag, input int idx, input logic [31:0] pc,
                               input logic adef);
        if (idx < seen_pc.size()) begin
            check({tag, "_pc"}, seen_pc[idx], pc);
            check({tag, "_inst"}, seen_inst[idx], adef ? 32'h0 : mem_word(pc));
            check({tag, "_adef"}, 32'(seen_adef[idx]), 32'(adef));
        end else begin
            check({tag, "_present"}, 32'(seen_pc.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int n;
        int a;
        reset = 1'b1; id_allowin = 1'b1; br_taken = 1'b0; br_target = 32'h0;
        ex_WB = 1'b0; flush_WB = 1'b0; ex_entry = 32'h0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
        mem_ack = 1'b1; dok_en = 1'b1; stray_dok = 1'b0;

        // Reset state and first request
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(to_valid), 32'd0);
        check("rst_req", 32'(inst_sram_req), 32'd0);
        check("rst_addr", inst_sram_addr, RESET_PC);
        check("sram_size", 32'(inst_sram_size), 32'd2);
        reset = 1'b0;
        tick();
        check("first_req", 32'(s_req), 32'd1);
        check("first_addr", s_addr, RESET_PC);

        // Streaming: back-to-back delivery in order
        run(7);
        for (int i = 0; i < 3; i++) expect_seen("stream", i, RESET_PC + 32'(4 * i), 1'b0);
        check("stream_gap01", 32'(seen_cycle(1) - seen_cycle(0)), 32'd1);
        check("stream_gap12", 32'(seen_cycle(2) - seen_cycle(1)), 32'd1);

        // ID stall: buffer fills to depth, requests stop, then in-order drain
        id_allowin = 1'b0;
        run(10);
        n = seen_pc.size();
        check("stall_req", 32'(s_req), 32'd0);
        check("stall_valid", 32'(s_valid), 32'd1);
        check("stall_head", s_pc, RESET_PC + 32'(4 * n));
        mem_ack = 1'b0;
        id_allowin = 1'b1;
        run(8);
        check("stall_drain_cnt", 32'(seen_pc.size()), 32'(n + 4));
        for (int i = 0; i < 4; i++) expect_seen("drain", n + i, RESET_PC + 32'(4 * (n + i)), 1'b0);

        // Branch with two requests in flight
        mem_ack = 1'b1;
        dok_en = 1'b0;
        run(3);
        check("hold_req", 32'(s_req), 32'd0);
        check("hold_inflight", 32'(mem_q.size()), 32'd2);
        br_taken = 1'b1; br_target = 32'h1c000100;
        tick();
        br_taken = 1'b0;
        n = seen_pc.size();
        dok_en = 1'b1;
        run(6);
        expect_seen("br_first", n, 32'h1c000100, 1'b0);
        expect_seen("br_second", n + 1, 32'h1c000104, 1'b0);

        // Exception beats branch; redirect lands together with a response
        dok_en = 1'b0;
        run(2);
        check("pre_ex_inflight", 32'(mem_q.size()), 32'd2);
        dok_en = 1'b1;
        br_taken = 1'b1; br_target = 32'h1c000200;
        ex_WB = 1'b1; ex_entry = 32'h1c008000;
        tick();
        br_taken = 1'b0; ex_WB = 1'b0;
        n = seen_pc.size();
        run(6);
        expect_seen("ex_first", n, 32'h1c008000, 1'b0);
        expect_seen("ex_second", n + 1, 32'h1c008004, 1'b0);

        // Misaligned target: one adef entry, no requests, stall until exception
        id_allowin = 1'b0;
        br_taken = 1'b1; br_target = 32'h1c000102;
        tick();
        br_taken = 1'b0;
        a = acc_cnt;
        run(6);
        check("adef_no_req", 32'(acc_cnt - a), 32'd0);
        check("adef_valid", 32'(s_valid), 32'd1);
        check("adef_pc", s_pc, 32'h1c000102);
        check("adef_flag", 32'(s_adef), 32'd1);
        check("adef_inst", s_inst, 32'h0);
        n = seen_pc.size();
        id_allowin = 1'b1;
        run(4);
        check("adef_once", 32'(seen_pc.size()), 32'(n + 1));
        expect_seen("adef_entry", n, 32'h1c000102, 1'b1);
        check("adef_stall_valid", 32'(s_valid), 32'd0);
        check("adef_stall_req", 32'(s_req), 32'd0);
        ex_WB = 1'b1; ex_entry = 32'h1c000300;
        tick();
        ex_WB = 1'b0;
        n = seen_pc.size();
        run(6);
        expect_seen("adef_resume", n, 32'h1c000300, 1'b0);

        // ertn redirect hides and flushes a non-empty buffer
        id_allowin = 1'b0;
        run(3);
        check("pre_flush_valid", 32'(s_valid), 32'd1);
        flush_WB = 1'b1; ex_entry = 32'h1c000400;
        tick();
        flush_WB = 1'b0;
        check("flush_valid_gated", 32'(s_valid), 32'd0);
        n = seen_pc.size();
        id_allowin = 1'b1;
        run(6);
        expect_seen("flush_first", n, 32'h1c000400, 1'b0);

        // Asynchronous reset with two in flight, stray response afterwards
        dok_en = 1'b0;
        run(2);
        check("pre_rst_inflight", 32'(mem_q.size()), 32'd2);
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(to_valid), 32'd0);
        check("arst_req", 32'(inst_sram_req), 32'd0);
        check("arst_addr", inst_sram_addr, RESET_PC);
        mem_q.delete();
        dok_en = 1'b1;
        run(2);
        reset = 1'b0;
        stray_dok = 1'b1;
        tick();
        stray_dok = 1'b0;
        check("rerst_req", 32'(s_req), 32'd1);
        check("rerst_addr", s_addr, RESET_PC);
        n = seen_pc.size();
        run(6);
        expect_seen("rerst_first", n, RESET_PC, 1'b0);
        expect_seen("rerst_second", n + 1, RESET_PC + 32'd4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
